// File: rtl/cfg_slv.sv
// cfg_slv: serial configuration slave, far end of the 2-wire config link.
//
// Receives 3-byte command frames (8N1, LSB first, MS byte first) on RX_C and
// presents them as a 24-bit command with a ready flag. On request it sends a
// 16-bit response (high byte first) on TX_C. RX and TX are independent.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   RX_C         serial command line in (idle high)
//   TX_C         serial response line out (idle high)
//   cmd          last complete command frame, first byte in [23:16]
//   cmd_rdy      new command available
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp         response word, captured when snd_resp is accepted
//   snd_resp     request to transmit resp (accepted only when idle)
//   tx_busy      response transmission in progress
//   resp_sent    one-cycle pulse when the response is fully sent
//   frm_err      one-cycle pulse on a bad stop bit
//
// RX states:
//   RX_IDLE   | waiting for a falling edge on the synchronised line
//   RX_START  | half-bit wait, then confirm the start bit is still low
//   RX_DATA   | sample 8 data bits, one per bit period
//   RX_STOP   | sample the stop bit; high = byte valid, low = framing error
//
// TX states:
//   TX_IDLE   | line high, waiting for snd_resp
//   TX_START1 | start bit of the high byte
//   TX_D1     | data bits of the high byte
//   TX_STOP1  | stop bit of the high byte
//   TX_START2 | start bit of the low byte
//   TX_D2     | data bits of the low byte
//   TX_STOP2  | stop bit of the low byte
module cfg_slv #(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX_C,
    output logic        TX_C,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [15:0] resp,
    input  logic        snd_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frm_err
);

    localparam int CW     = $clog2(BAUD_DIV);
    localparam int GAP_TC = GAP_BITS * BAUD_DIV;
    localparam int GW     = $clog2(GAP_TC);

    localparam logic [CW-1:0] BIT_LD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP_TC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START1, TX_D1, TX_STOP1,
                              TX_START2, TX_D2, TX_STOP2} tx_state_t;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [1:0]      idx_q, idx_d;
    logic [23:0]     stage_q, stage_d;
    logic [23:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            frm_err_q, frm_err_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            byte_vld;
    logic            rx_fall;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic [7:0]      tx_lo_q, tx_lo_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_busy_q, tx_busy_d;
    logic            resp_sent_q, resp_sent_d;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // RX bit-level receiver
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        byte_vld   = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LD;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_s2_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LD;
                        rx_bit_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = BIT_LD;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) byte_vld  = 1'b1;
                    else         frm_err_d = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame assembler and inter-byte gap timer
    always_comb begin
        idx_d     = idx_q;
        stage_d   = stage_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        gap_d     = gap_q;
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
        if (byte_vld) begin
            case (idx_q)
                2'd0: begin
                    stage_d[23:16] = rx_sh_q;
                    idx_d          = 2'd1;
                end
                2'd1: begin
                    stage_d[15:8] = rx_sh_q;
                    idx_d         = 2'd2;
                end
                default: begin
                    // Completion overrides a same-cycle clear
                    stage_d[7:0] = rx_sh_q;
                    cmd_d        = {stage_q[23:8], rx_sh_q};
                    cmd_rdy_d    = 1'b1;
                    idx_d        = 2'd0;
                end
            endcase
        end
        if (frm_err_d) idx_d = 2'd0;
        // Timer only advances while a partial frame waits in RX_IDLE; it
        // holds during reception because leaving IDLE always reloads it.
        if (idx_q == 2'd0 || (rx_state_q == RX_IDLE && rx_fall)) begin
            gap_d = GAP_LD;
        end else if (rx_state_q == RX_IDLE) begin
            if (gap_q == '0) begin
                idx_d   = 2'd0;
                stage_d = '0;
                gap_d   = GAP_LD;
            end else begin
                gap_d = gap_q - GW'(1);
            end
        end
    end

    // TX serialiser; each bit held for BAUD_DIV cycles by the down-counter
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        tx_lo_d     = tx_lo_q;
        tx_line_d   = tx_line_q;
        tx_busy_d   = tx_busy_q;
        resp_sent_d = 1'b0;
        if (tx_state_q == TX_IDLE) begin
            if (snd_resp) begin
                tx_state_d = TX_START1;
                tx_sh_d    = resp[15:8];
                tx_lo_d    = resp[7:0];
                tx_line_d  = 1'b0;
                tx_busy_d  = 1'b1;
                tx_cnt_d   = BIT_LD;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
            tx_cnt_d = BIT_LD;
            case (tx_state_q)
                TX_START1, TX_START2: begin
                    tx_state_d = (tx_state_q == TX_START1) ? TX_D1 : TX_D2;
                    tx_line_d  = tx_sh_q[0];
                    tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d   = 3'd0;
                end
                TX_D1, TX_D2: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = (tx_state_q == TX_D1) ? TX_STOP1 : TX_STOP2;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_line_d = tx_sh_q[0];
                        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d  = tx_bit_q + 3'd1;
                    end
                end
                TX_STOP1: begin
                    tx_state_d = TX_START2;
                    tx_line_d  = 1'b0;
                    tx_sh_d    = tx_lo_q;
                end
                TX_STOP2: begin
                    tx_state_d  = TX_IDLE;
                    tx_line_d   = 1'b1;
                    tx_busy_d   = 1'b0;
                    resp_sent_d = 1'b1;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_line_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            idx_q       <= '0;
            stage_q     <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            gap_q       <= GAP_LD;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_lo_q     <= '0;
            tx_line_q   <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_s1_q     <= RX_C;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frm_err_q   <= frm_err_d;
            gap_q       <= gap_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_lo_q     <= tx_lo_d;
            tx_line_q   <= tx_line_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX_C      = tx_line_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign tx_busy   = tx_busy_q;
    assign resp_sent = resp_sent_q;
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_cfg_slv.sv
`timescale 1ns/1ps
module tb_cfg_slv;

    localparam int BAUD = 16;
    localparam int GAPB = 4;
    localparam int TX_LEN = 20 * BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX_C = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        snd_resp = 1'b0;
    logic [15:0] resp = 16'h0;
    logic        TX_C;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;

    cfg_slv #(.BAUD_DIV(BAUD), .GAP_BITS(GAPB)) dut (
        .clk(clk), .rst(rst), .RX_C(RX_C), .TX_C(TX_C),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .snd_resp(snd_resp), .tx_busy(tx_busy),
        .resp_sent(resp_sent), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response model: a response is a 20-bit frame, each bit BAUD cycles wide
    logic        m_act;
    int          m_t;
    logic [19:0] m_frame;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if ((!m_act || m_t >= TX_LEN) && snd_resp) begin
            m_act   <= 1'b1;
            m_t     <= 0;
            m_frame <= {1'b1, resp[7:0], 1'b0, 1'b1, resp[15:8], 1'b0};
        end else if (m_act) begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic e_tx, e_busy, e_sent;
        if (!rst) begin
            e_tx = 1'b1; e_busy = 1'b0; e_sent = 1'b0;
            if (m_act && m_t < TX_LEN) begin
                e_tx   = m_frame[m_t / BAUD];
                e_busy = 1'b1;
            end else if (m_act && m_t == TX_LEN) begin
                e_sent = 1'b1;
            end
            chk("tx_c", 32'(TX_C), 32'(e_tx));
            chk("tx_busy", 32'(tx_busy), 32'(e_busy));
            chk("resp_sent", 32'(resp_sent), 32'(e_sent));
        end
    end

    // Monitors
    int   frm_cnt = 0;
    int   busy_cnt = 0;
    int   sent_cnt = 0;
    logic dead_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (frm_err) frm_cnt++;
            if (tx_busy) busy_cnt++;
            if (resp_sent) sent_cnt++;
            if (cmd[23:8] == 16'hDEAD || cmd[15:0] == 16'hDEAD) dead_seen = 1'b1;
        end
    end

    // Command model: valid bytes queue up; three make a command
    logic [7:0]  m_q[$];
    logic [23:0] m_cmd = 24'h0;
    logic        m_rdy = 1'b0;
    int          m_frm = 0;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        RX_C = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX_C = b[i];
            wait_cyc(BAUD);
        end
        RX_C = stop_ok;
        wait_cyc(BAUD);
        if (!stop_ok) begin
            RX_C = 1'b1;
            wait_cyc(BAUD);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_q.push_back(b);
        if (m_q.size() == 3) begin
            m_cmd = {m_q[0], m_q[1], m_q[2]};
            m_rdy = 1'b1;
            m_q.delete();
        end
    endtask

    task automatic check_cmd();
        chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
    endtask

    // Idle above ~70 cycles exceeds the GAPB*BAUD timeout; below 40 never does
    task automatic rx_byte(input logic [7:0] b, input logic ok, input int idle);
        send_byte(b, ok);
        if (ok) model_byte(b);
        else begin
            m_q.delete();
            m_frm++;
        end
        check_cmd();
        if (idle > 0) wait_cyc(idle);
        if (idle >= 70) m_q.delete();
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        wait_cyc(1);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check_cmd();
    endtask

    task automatic glitch();
        RX_C = 1'b0;
        wait_cyc(4);
        RX_C = 1'b1;
        wait_cyc(24);
    endtask

    logic [9:0] exp_bits;

    initial begin
        // Reset values
        wait_cyc(3);
        chk("rst_tx_c", 32'(TX_C), 32'd1);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_resp_sent", 32'(resp_sent), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        wait_cyc(5);

        // Clean frame
        rx_byte(8'hA5, 1'b1, 0);
        rx_byte(8'h3C, 1'b1, 0);
        rx_byte(8'h81, 1'b1, 0);
        chk("clean_cmd_lit", 32'(cmd), 32'hA53C81);
        chk("clean_rdy_lit", 32'(cmd_rdy), 32'd1);
        chk("clean_no_frm_err", 32'(frm_cnt), 32'd0);
        clear_rdy();
        chk("clr_cmd_hold_lit", 32'(cmd), 32'hA53C81);

        // Response 0xBEEF with an ignored second request mid-frame
        busy_cnt = 0;
        sent_cnt = 0;
        exp_bits = {1'b1, 8'hBE, 1'b0};
        resp = 16'hBEEF;
        snd_resp = 1'b1;
        wait_cyc(1);
        snd_resp = 1'b0;
        fork
            begin
                wait_cyc(7);
                for (int j = 0; j < 10; j++) begin
                    chk($sformatf("tx_bit_lit%0d", j), 32'(TX_C), 32'(exp_bits[j]));
                    wait_cyc(BAUD);
                end
            end
            begin
                wait_cyc(60);
                resp = 16'h1234;
                snd_resp = 1'b1;
                wait_cyc(1);
                snd_resp = 1'b0;
            end
        join
        wait_cyc(200);
        chk("busy_len_lit", 32'(busy_cnt), 32'd320);
        chk("resp_sent_cnt_lit", 32'(sent_cnt), 32'd1);

        // Glitch and framing error
        glitch();
        rx_byte(8'h11, 1'b0, 0);
        chk("frm_err_cnt_lit", 32'(frm_cnt), 32'd1);
        rx_byte(8'h12, 1'b1, 0);
        glitch();
        rx_byte(8'h34, 1'b1, 0);
        rx_byte(8'h56, 1'b1, 0);
        chk("frm_cmd_lit", 32'(cmd), 32'h123456);
        clear_rdy();

        // Gap timeout
        rx_byte(8'hDE, 1'b1, 0);
        rx_byte(8'hAD, 1'b1, 5 * BAUD);
        rx_byte(8'h01, 1'b1, 0);
        rx_byte(8'h02, 1'b1, 0);
        rx_byte(8'h03, 1'b1, 0);
        chk("gap_cmd_lit", 32'(cmd), 32'h010203);
        chk("gap_no_dead", 32'(dead_seen), 32'd0);
        clear_rdy();

        // Completion in the same cycle as clear: set wins
        rx_byte(8'h9A, 1'b1, 0);
        rx_byte(8'hBC, 1'b1, 0);
        fork
            send_byte(8'h4D, 1'b1);
            begin
                wait_cyc(154);
                clr_cmd_rdy = 1'b1;
                wait_cyc(1);
                clr_cmd_rdy = 1'b0;
            end
        join
        model_byte(8'h4D);
        check_cmd();
        chk("coll_cmd_lit", 32'(cmd), 32'h9ABC4D);
        chk("coll_rdy_lit", 32'(cmd_rdy), 32'd1);
        rx_byte(8'h55, 1'b1, 0);
        rx_byte(8'h66, 1'b1, 0);
        rx_byte(8'h77, 1'b1, 0);
        chk("ovr_cmd_lit", 32'(cmd), 32'h556677);
        chk("ovr_rdy_lit", 32'(cmd_rdy), 32'd1);

        // Reset during response D1 and command DATA
        resp = 16'hC3A5;
        snd_resp = 1'b1;
        wait_cyc(1);
        snd_resp = 1'b0;
        RX_C = 1'b0;
        wait_cyc(40);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_c", 32'(TX_C), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_cmd", 32'(cmd), 32'd0);
        chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
        m_q.delete();
        m_cmd = 24'h0;
        m_rdy = 1'b0;
        RX_C = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        rx_byte(8'h0F, 1'b1, 0);
        rx_byte(8'h0F, 1'b1, 0);
        rx_byte(8'h0F, 1'b1, 0);
        chk("post_rst_cmd_lit", 32'(cmd), 32'h0F0F0F);
        clear_rdy();

        // Randomised full-duplex traffic
        fork
            begin
                for (int f = 0; f < 12; f++) begin
                    for (int k = 0; k < 3; k++) begin
                        logic [7:0] b;
                        logic       ok;
                        int         idle;
                        b    = 8'($urandom);
                        ok   = ($urandom_range(0, 9) != 0);
                        idle = ($urandom_range(0, 5) == 0) ? int'($urandom_range(80, 110))
                                                           : int'($urandom_range(0, 30));
                        rx_byte(b, ok, idle);
                    end
                    if ($urandom_range(0, 2) == 0) clear_rdy();
                end
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    wait_cyc(int'($urandom_range(20, 400)));
                    resp = 16'($urandom);
                    snd_resp = 1'b1;
                    wait_cyc(1);
                    snd_resp = 1'b0;
                end
            end
        join
        wait_cyc(400);
        chk("frm_err_total", 32'(frm_cnt), 32'(m_frm));
        check_cmd();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_slv.md
Name: cfg_slv

Overview:
- Serial configuration slave: the far-end peer of the configuration master on the same 2-wire link.
- Deserialises 3-byte command frames (8N1, LSB first, MS byte first) arriving on RX_C and presents each as a 24-bit command with a ready flag.
- On request, serialises a 16-bit response (high byte first) on TX_C.
- Self-contained: contains its own bit-level receiver, transmitter, frame assembler and inter-byte gap timer.

Parameters:
BAUD_DIV, 2604, clk cycles per bit period (>=8); 50 MHz / 19200 baud
GAP_BITS, 32, idle bit periods between bytes after which a partial frame is discarded

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
RX_C  input  1  serial command line from master (idle high)
TX_C  output  1  serial response line to master (idle high)
cmd  output  24  last complete command frame, byte0 in [23:16]
cmd_rdy  output  1  new command available
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  16  response word, sampled when snd_resp accepted
snd_resp  input  1  request to transmit resp
tx_busy  output  1  response transmission in progress
resp_sent  output  1  one-cycle pulse when response fully sent
frm_err  output  1  one-cycle pulse on bad stop bit

Behaviour:
- One clock. Reset is asynchronous and active-high. Reset values: TX_C=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0. RX synchroniser flops reset to 1.
- Reset mid-operation aborts RX, assembler and TX immediately. TX_C returns high asynchronously.
- RX_C passes through a 2-flop synchroniser. All RX timing uses the synchronised signal.
- RX FSM states:
  - IDLE -> START on synchronised falling edge; load bit counter with BAUD_DIV/2.
  - START: at count expiry, if line is low -> DATA and reload BAUD_DIV; else -> IDLE (glitch reject, nothing reported).
  - DATA: sample every BAUD_DIV cycles, 8 bits, shift in LSB first -> STOP.
  - STOP: sample after BAUD_DIV cycles.
    - Line high: byte valid.
    - Line low: frm_err pulse, byte dropped, assembler index reset to 0.
    - Either way -> IDLE. New start edge is accepted the cycle after.
- Frame assembler:
  - 2-bit byte index, 0..2. Each valid byte is written to a 24-bit staging register at [23:16], [15:8], [7:0] for index 0, 1, 2.
  - On the valid byte with index 2: staging register is copied to cmd in the same cycle, cmd_rdy is set on the next clock edge, and the index returns to 0.
  - cmd never shows a partial frame.
  - A completion while cmd_rdy is already 1 overwrites cmd; cmd_rdy stays 1.
  - clr_cmd_rdy clears cmd_rdy. If completion and clr_cmd_rdy occur in the same cycle, set wins.
- Gap timer:
  - Runs while index != 0 and RX FSM is IDLE.
  - Resets on every start edge.
  - When it reaches GAP_BITS*BAUD_DIV cycles, index is forced to 0 and staged bytes are discarded.
  - No error pulse.
- TX FSM states:
  - IDLE: snd_resp is accepted only here. Latch resp, set tx_busy -> START1.
  - START1 -> D1 (8 bits) -> STOP1 -> START2 -> D2 (8 bits) -> STOP2 -> IDLE.
  - Each bit is driven for exactly BAUD_DIV cycles. TX_C is low in START1 beginning the cycle after acceptance.
  - Byte 1 = resp[15:8], byte 2 = resp[7:0], LSB first. No idle gap between STOP1 and START2.
  - After STOP2 completes: tx_busy=0 and resp_sent=1 for one cycle.
  - Total busy time is 20*BAUD_DIV cycles.
  - snd_resp while tx_busy is ignored, with no queueing.
- RX and TX are fully independent, so full duplex is allowed.

Test Plan:
All scenarios use BAUD_DIV=16, GAP_BITS=4.
- Clean frame: drive bytes 0xA5, 0x3C, 0x81 back-to-back on RX_C -> cmd=0xA53C81, cmd_rdy=1 after the third stop sample, frm_err never pulses. Then pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd holds.
- Response: with resp=0xBEEF, pulse snd_resp for 1 cycle.
  - TX_C low the next cycle, then bits of 0xBE LSB first (0,1,1,1,1,1,0,1), a stop bit, then 0xEF, each 16 cycles wide.
  - tx_busy high for 320 cycles, then resp_sent pulses once.
  - A second snd_resp sent mid-frame with resp=0x1234 has no effect on TX_C.
- Glitch and framing: a 4-cycle low pulse on RX_C -> no byte, index unchanged.
  - Byte 0x11 with stop bit driven low -> frm_err pulse.
  - Then 0x12, 0x34, 0x56 -> cmd=0x123456.
- Gap timeout: send 0xDE, 0xAD, idle 5 bit periods, then 0x01, 0x02, 0x03 -> cmd=0x010203, and no frame is ever formed containing 0xDEAD.
- Collisions: a frame completes in the same cycle clr_cmd_rdy is asserted -> cmd_rdy=1 with the new cmd.
  - A second frame arriving before clear -> cmd overwritten, cmd_rdy stays 1.
- Reset mid-transfer: assert rst during D1 of a response and during DATA of a command -> TX_C=1 and tx_busy=0 immediately, cmd=0.
  - After release, a full new frame 0x0F0F0F is received correctly.
